div_seq_ctrl32: RTL

//  Sequential 32-bit unsigned restoring divider: controller that steps the 32-bit ripple

---
 rtl/div_seq_ctrl32_pkg.sv | 10 +
 rtl/div_seq_ctrl32_ripple.sv | 16 +
 rtl/div_seq_ctrl32.sv | 88 ++++++++
 3 files changed

// File: rtl/div_seq_ctrl32_pkg.sv
// div_seq_ctrl32_pkg: state encodings and constants shared by the sequential divider
package div_seq_ctrl32_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   localparam logic [4:0]  LAST_STEP   = 5'd31;
   localparam logic [31:0] DBZ_DEFAULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_seq_ctrl32_ripple.sv
// Ripple32bit: 32-bit ripple-carry adder with carry in and carry out
module Ripple32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cIn,
   output logic [31:0] s,
   output logic        c
);
   logic [32:0] cy;
   assign cy[0] = cIn;
   assign c     = cy[32];
   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign s[i]    = a[i] ^ b[i] ^ cy[i];
      assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
   end
endmodule

// File: rtl/div_seq_ctrl32.sv
// div_seq_ctrl32: restoring divider stepping one quotient bit per cycle through a shared ripple adder
module div_seq_ctrl32
   import div_seq_ctrl32_pkg::*;
#(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] DBZ_QUOT = DBZ_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   state_t           state;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] q, r, d, nd, rs, diff, q_nxt, r_nxt;
   logic             ovf, cout, take;
   for (genvar i = 0; i < WIDTH; i++) begin : g_inv
      not u_inv (nd[i], d[i]);
   end
   assign rs    = {r[WIDTH-2:0], q[WIDTH-1]};
   assign ovf   = r[WIDTH-1];
   assign take  = ovf | cout;
   assign q_nxt = {q[WIDTH-2:0], take};
   assign r_nxt = take ? diff : rs;
   // rs - d as rs + ~d + 1; carry out set means no borrow
   Ripple32bit u_add (
      .a  (rs),
      .b  (nd),
      .cIn(1'b1),
      .s  (diff),
      .c  (cout)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         q           <= '0;
         r           <= '0;
         d           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_RUN: begin
               q   <= q_nxt;
               r   <= r_nxt;
               cnt <= cnt + 5'd1;
               if (cnt == LAST_STEP) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_nxt;
                  remainder <= r_nxt;
               end
            end
            default: begin
               state <= ST_IDLE;
               if (start) begin
                  q           <= dividend;
                  r           <= '0;
                  d           <= divisor;
                  cnt         <= '0;
                  div_by_zero <= divisor == '0;
                  if (divisor == '0) begin
                     state     <= ST_DONE;
                     done      <= 1'b1;
                     quotient  <= DBZ_QUOT;
                     remainder <= dividend;
                  end else begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule
